// File: rtl/multi_duration_fsm_pkg.sv
// Shared types and defaults for the multi-channel duration timer.
// Optional feature: DUR_PAUSE_EN adds a per-channel pause input.
package multi_duration_fsm_pkg;

    // Per-channel timer state; encoding is fixed so state can be probed in hardware.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FINISH = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_CNT_W  = 8;

endpackage

// File: rtl/multi_duration_fsm_ch.sv
// One go/kill/done duration timer channel.
// Optional feature: DUR_PAUSE_EN adds a pause input that freezes counting in ACTIVE.
module duration_fsm_ch
    import multi_duration_fsm_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             kill,
`ifdef DUR_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [CNT_W-1:0] duration,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic             done_set
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] dur_q_reg, dur_q_next;
    logic [CNT_W-1:0] last_cnt;
    logic             advance;

    // A paused channel neither counts nor completes; without the feature it always advances.
`ifdef DUR_PAUSE_EN
    assign advance = ~pause;
`else
    assign advance = 1'b1;
`endif

    // dur_q is never 0 once latched, so this never underflows in ACTIVE.
    assign last_cnt = dur_q_reg - CNT_W'(1);

    // Next-state logic: kill beats completion and pause; go only matters in IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dur_q_next = dur_q_reg;
        unique case (state_reg)
            IDLE: begin
                if (go && !kill) begin
                    state_next = ACTIVE;
                    dur_q_next = (duration == '0) ? CNT_W'(1) : duration;
                    cnt_next   = '0;
                end
            end
            ACTIVE: begin
                if (kill) begin
                    state_next = ABORT;
                end else if (advance) begin
                    if (cnt_reg == last_cnt) begin
                        state_next = FINISH;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            ABORT: begin
                if (!kill) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Lets the top register done_any in the same cycle the done flop rises.
    assign done_set = (state_next == FINISH);

    // State, counter and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dur_q_reg <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dur_q_reg <= dur_q_next;
            done      <= (state_next == FINISH);
            aborted   <= (state_next == ABORT) && (state_reg != ABORT);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: rtl/multi_duration_fsm.sv
// NUM_CH independent duration timers with a shared done_any flag.
// Optional feature: DUR_PAUSE_EN adds the per-channel pause bus.
module multi_duration_fsm
    import multi_duration_fsm_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       go,
    input  logic [NUM_CH-1:0]       kill,
    input  logic [NUM_CH*CNT_W-1:0] duration,
`ifdef DUR_PAUSE_EN
    input  logic [NUM_CH-1:0]       pause,
`endif
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       aborted,
    output logic [NUM_CH-1:0]       busy,
    output logic                    done_any
);

    logic [NUM_CH-1:0] done_set;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            duration_fsm_ch #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .go       (go[gi]),
                .kill     (kill[gi]),
`ifdef DUR_PAUSE_EN
                .pause    (pause[gi]),
`endif
                .duration (duration[gi*CNT_W +: CNT_W]),
                .done     (done[gi]),
                .aborted  (aborted[gi]),
                .busy     (busy[gi]),
                .done_set (done_set[gi])
            );
        end
    endgenerate

    // Registered OR of the channels' done, aligned with the done flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_any <= 1'b0;
        end else begin
            done_any <= |done_set;
        end
    end

endmodule

// File: tb/tb_multi_duration_fsm.sv
// Bench for multi_duration_fsm: directed scenarios plus random traffic,
// checked every cycle against a remaining-work reference model.
module tb_multi_duration_fsm;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       go;
    logic [NUM_CH-1:0]       kill;
    logic [NUM_CH-1:0]       pause;
    logic [NUM_CH*CNT_W-1:0] duration;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       aborted;
    logic [NUM_CH-1:0]       busy;
    logic                    done_any;

    multi_duration_fsm #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .kill     (kill),
        .duration (duration),
`ifdef DUR_PAUSE_EN
        .pause    (pause),
`endif
        .done     (done),
        .aborted  (aborted),
        .busy     (busy),
        .done_any (done_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int done_any_cnt = 0;

    // Reference model: each channel is idle, running with some work left,
    // showing its done cycle, or held in abort.
    int mode [NUM_CH];   // 0 idle, 1 running, 2 done cycle, 3 aborting
    int left [NUM_CH];   // active (unpaused) cycles still owed
    logic [NUM_CH-1:0] exp_done, exp_abort, exp_busy;
    logic              exp_done_any;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mode[c] = 0;
            left[c] = 0;
        end
        exp_done = '0; exp_abort = '0; exp_busy = '0; exp_done_any = 1'b0;
    endtask

    // Applies one clock edge worth of the current inputs to the model.
    task automatic model_edge();
        int d;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_done[c]  = 1'b0;
            exp_abort[c] = 1'b0;
            case (mode[c])
                0: if (go[c] && !kill[c]) begin
                    d = int'(duration[c*CNT_W +: CNT_W]);
                    left[c] = (d == 0) ? 1 : d;
                    mode[c] = 1;
                    $display("cycle %0d ch%0d start D=%0d", cycle, c, d);
                end
                1: if (kill[c]) begin
                    mode[c] = 3;
                    exp_abort[c] = 1'b1;
                end else if (!pause[c]) begin
                    left[c]--;
                    if (left[c] == 0) begin
                        mode[c] = 2;
                        exp_done[c] = 1'b1;
                    end
                end
                2: mode[c] = 0;
                default: if (!kill[c]) mode[c] = 0;
            endcase
            exp_busy[c] = (mode[c] != 0);
        end
        exp_done_any = |exp_done;
    endtask

    task automatic compare_all();
        check_val("done",     32'(done),     32'(exp_done));
        check_val("aborted",  32'(aborted),  32'(exp_abort));
        check_val("busy",     32'(busy),     32'(exp_busy));
        check_val("done_any", 32'(done_any), 32'(exp_done_any));
        if (done_any === 1'b1) done_any_cnt++;
    endtask

    // Inputs are set at the negedge before calling; one clock, then check.
    task automatic step();
        @(posedge clk);
        model_edge();
        cycle++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        go = '0; kill = '0; pause = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_dur(input int c, input int d);
        duration[c*CNT_W +: CNT_W] = CNT_W'(d);
    endtask

    task automatic start(input int c, input int d);
        go = '0; kill = '0; pause = '0;
        set_dur(c, d);
        go[c] = 1'b1;
        step();
        go = '0;
    endtask

    initial begin
        rst_n = 1'b0; go = '0; kill = '0; pause = '0; duration = '0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Long single timer.
        start(0, 100);
        idle(104);

        // Kill mid-count held for three cycles.
        start(1, 10);
        idle(4);
        kill[1] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        idle(4);

        // Kill on the final active cycle, then minimum and maximum durations.
        start(2, 10);
        idle(9);
        kill[2] = 1'b1;
        step();
        idle(4);
        start(2, 0);
        idle(4);
        start(2, 255);
        idle(258);

        // All channels together; go held while active must be ignored.
        set_dur(0, 3); set_dur(1, 3); set_dur(2, 7); set_dur(3, 1);
        done_any_cnt = 0;
        go = '1;
        for (int i = 0; i < 3; i++) step();
        idle(10);
        check_val("done_any_cycles", 32'(done_any_cnt), 32'd3);

        // Asynchronous reset mid-count, then a fresh start.
        start(0, 50);
        idle(10);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        idle(60);
        start(0, 5);
        idle(8);

`ifdef DUR_PAUSE_EN
        // Pause extends the count; pause with kill still aborts.
        start(3, 10);
        idle(3);
        pause[3] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle(12);
        start(3, 10);
        idle(2);
        pause[3] = 1'b1; kill[3] = 1'b1;
        step();
        idle(4);
`endif

        // Random traffic on all channels.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                go[c]   = ($urandom_range(0, 3) == 0);
                kill[c] = ($urandom_range(0, 15) == 0);
`ifdef DUR_PAUSE_EN
                pause[c] = ($urandom_range(0, 7) == 0);
`endif
                set_dur(c, ($urandom_range(0, 63) == 0) ? 255 : int'($urandom_range(0, 15)));
            end
            step();
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
